// File: rtl/seq_fixed_point_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_fixed_point_div                                             |
// | Purpose  : Multi-cycle signed fixed-point restoring divider, BPC bits/cycle,|
// |            valid/ready handshakes, rounding, saturation, div-by-zero flag. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module seq_fixed_point_div #(
    parameter int WIIA  = 8,
    parameter int WIFA  = 8,
    parameter int WIIB  = 8,
    parameter int WIFB  = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROUND = 1,
    parameter int BPC   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIIA+WIFA-1:0]   dividend,
    input  logic [WIIB+WIFB-1:0]   divisor,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WOI+WOF-1:0]     out,
    output logic                   upflow,
    output logic                   downflow,
    output logic                   div_zero
);

    localparam int c_wa  = WIIA + WIFA;
    localparam int c_wb  = WIIB + WIFB;
    localparam int c_n   = WOI + WOF;
    localparam int c_wri = (WOI + WIIB > WIIA) ? (WOI + WIIB) : WIIA;
    localparam int c_wrf = (WOF + WIFB > WIFA) ? (WOF + WIFB) : WIFA;
    localparam int c_wr  = c_wri + c_wrf;
    localparam int c_wd  = c_wr + WOI;
    localparam int c_cw  = $clog2(c_n + 1) + 1;
    localparam logic [c_cw-1:0] c_bpc = c_cw'(BPC);
    localparam logic [c_cw-1:0] c_nb  = c_cw'(c_n);
    localparam logic [c_n-1:0]  c_max = {1'b0, {(c_n-1){1'b1}}};
    localparam logic [c_n-1:0]  c_min = {1'b1, {(c_n-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_sign;
    logic               r_sa;
    logic               r_dz;
    logic [c_wr-1:0]    r_divd;
    logic [c_wr-1:0]    r_divr;
    logic [c_wr-1:0]    r_rem;
    logic [c_wd-1:0]    r_dcur;
    logic [c_n-1:0]     r_q;
    logic [c_cw-1:0]    r_left;

    logic               w_accept;
    logic [c_wa-1:0]    w_mag_a;
    logic [c_wb-1:0]    w_mag_b;
    logic [c_wr-1:0]    w_divd;
    logic [c_wr-1:0]    w_divr;
    logic [c_wr-1:0]    w_rem;
    logic [c_wd-1:0]    w_dcur;
    logic [c_n-1:0]     w_q;
    logic [c_wr-1:0]    w_s;
    logic               w_rnd;
    logic [c_n-1:0]     w_qr;
    logic [c_n-1:0]     w_out;
    logic               w_up;
    logic               w_dn;

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid && in_ready;

    // Magnitudes are taken as unsigned so the most negative input maps to 2^(W-1)
    assign w_mag_a = dividend[c_wa-1] ? -dividend : dividend;
    assign w_mag_b = divisor[c_wb-1]  ? -divisor  : divisor;
    assign w_divd  = c_wr'(w_mag_a) << (c_wrf - WIFA);
    assign w_divr  = c_wr'(w_mag_b) << (c_wrf - WIFB);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept)         w_next = S_CALC;
            S_CALC: if (r_left <= c_bpc)  w_next = S_FIX;
            S_FIX:                        w_next = S_DONE;
            S_DONE: if (out_ready)        w_next = S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    // r_dcur holds divr*2^j for the next bit; the remainder is divd - acc
    always_comb begin
        w_rem  = r_rem;
        w_dcur = r_dcur;
        w_q    = r_q;
        for (int b = 0; b < BPC; b++) begin
            if (c_cw'(b) < r_left) begin
                if (c_wd'(w_rem) >= w_dcur) begin
                    w_rem = w_rem - w_dcur[c_wr-1:0];
                    w_q   = {w_q[c_n-2:0], 1'b1};
                end else begin
                    w_q   = {w_q[c_n-2:0], 1'b0};
                end
                w_dcur = w_dcur >> 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_sa   <= 1'b0;
            r_dz   <= 1'b0;
            r_divd <= '0;
            r_divr <= '0;
            r_rem  <= '0;
            r_dcur <= '0;
            r_q    <= '0;
            r_left <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_sign <= dividend[c_wa-1] ^ divisor[c_wb-1];
                r_sa   <= dividend[c_wa-1];
                r_dz   <= (divisor == '0);
                r_divd <= w_divd;
                r_divr <= w_divr;
                r_rem  <= w_divd;
                r_dcur <= c_wd'(w_divr) << (WOI - 1);
                r_q    <= '0;
                r_left <= c_nb;
            end
        end else if (r_state == S_CALC) begin
            r_rem  <= w_rem;
            r_dcur <= w_dcur;
            r_q    <= w_q;
            r_left <= (r_left > c_bpc) ? (r_left - c_bpc) : '0;
        end
    end

    // Round half down: increment only when the remainder exceeds half an output LSB
    assign w_s   = r_divr >> WOF;
    assign w_rnd = (ROUND != 0) && !(&r_q) && ({r_rem, 1'b0} > {1'b0, w_s});
    assign w_qr  = r_q + c_n'(w_rnd);

    always_comb begin
        w_out = '0;
        w_up  = 1'b0;
        w_dn  = 1'b0;
        if (r_dz) begin
            if (r_sa) begin
                w_out = c_min;
                w_dn  = 1'b1;
            end else if (r_divd != '0) begin
                w_out = c_max;
                w_up  = 1'b1;
            end
        end else if (w_qr[c_n-1]) begin
            if (r_sign) begin
                w_out = c_min;
                w_dn  = |w_qr[c_n-2:0];
            end else begin
                w_out = c_max;
                w_up  = 1'b1;
            end
        end else begin
            w_out = r_sign ? -w_qr : w_qr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out      <= '0;
            upflow   <= 1'b0;
            downflow <= 1'b0;
            div_zero <= 1'b0;
        end else if (r_state == S_FIX) begin
            out      <= w_out;
            upflow   <= w_up;
            downflow <= w_dn;
            div_zero <= r_dz;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_fixed_point_div.sv
`default_nettype none
// Directed-vector bench for seq_fixed_point_div: three instances cover
// round-to-nearest, truncation and a 4-bit-per-cycle radix.
module tb_seq_fixed_point_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dividend = '0;
    logic [15:0] divisor  = '0;
    logic [2:0]  iv   = '0;
    logic [2:0]  ordy = '1;
    logic [2:0]  irdy, ov, upf, dnf, dzf;
    logic [15:0] q0, q1, q2;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    seq_fixed_point_div #(.ROUND(1), .BPC(1)) u_r1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
        .dividend(dividend), .divisor(divisor), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out(q0), .upflow(upf[0]), .downflow(dnf[0]), .div_zero(dzf[0]));

    seq_fixed_point_div #(.ROUND(0), .BPC(1)) u_t1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
        .dividend(dividend), .divisor(divisor), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out(q1), .upflow(upf[1]), .downflow(dnf[1]), .div_zero(dzf[1]));

    seq_fixed_point_div #(.ROUND(1), .BPC(4)) u_r4 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
        .dividend(dividend), .divisor(divisor), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out(q2), .upflow(upf[2]), .downflow(dnf[2]), .div_zero(dzf[2]));

    // flags packed as {upflow, downflow, div_zero}
    logic [15:0] va [11] = '{16'h0300, 16'hF900, 16'h0700, 16'hF900, 16'h0200, 16'h0100,
                             16'h6400, 16'h9C00, 16'h8000, 16'h0500, 16'h0000};
    logic [15:0] vb [11] = '{16'h0200, 16'h0200, 16'hFE00, 16'hFE00, 16'h0300, 16'h0300,
                             16'h0040, 16'h0040, 16'h0100, 16'h0000, 16'h0000};
    logic [15:0] vq [11] = '{16'h0180, 16'hFC80, 16'hFC80, 16'h0380, 16'h00AB, 16'h0055,
                             16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h0000};
    logic [2:0]  vf [11] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                             3'b100, 3'b010, 3'b000, 3'b101, 3'b001};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_div(input int u, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] o, output logic [2:0] fl, output int lat);
        int w;
        w = 0;
        while (!irdy[u] && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready_idle", 32'(irdy[u]), 32'd1);
        dividend = a;
        divisor  = b;
        iv[u]    = 1'b1;
        @(posedge clk); #1;
        iv[u] = 1'b0;
        lat   = 1;
        while (!ov[u] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        o  = (u == 0) ? q0 : (u == 1) ? q1 : q2;
        fl = {upf[u], dnf[u], dzf[u]};
    endtask

    initial begin
        logic [15:0] o;
        logic [2:0]  fl;
        int          lat;
        logic        seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(irdy), 32'd0);
        chk("rst_out_valid", 32'(ov), 32'd0);
        chk("rst_out", 32'(q0), 32'd0);
        chk("rst_flags", 32'({upf, dnf, dzf}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_rst", 32'(irdy), 32'd7);

        for (int i = 0; i < 11; i++) begin
            do_div(0, va[i], vb[i], o, fl, lat);
            chk($sformatf("r1_out_%0d", i), 32'(o), 32'(vq[i]));
            chk($sformatf("r1_flags_%0d", i), 32'(fl), 32'(vf[i]));
            chk($sformatf("r1_latency_%0d", i), 32'(lat), 32'd18);
        end

        do_div(1, 16'h0200, 16'h0300, o, fl, lat);
        chk("trunc_2_3", 32'(o), 32'h00AA);
        do_div(1, 16'h0100, 16'h0300, o, fl, lat);
        chk("trunc_1_3", 32'(o), 32'h0055);
        chk("trunc_flags", 32'(fl), 32'd0);

        do_div(2, 16'h0300, 16'h0200, o, fl, lat);
        chk("bpc4_out", 32'(o), 32'h0180);
        chk("bpc4_latency", 32'(lat), 32'd6);
        do_div(2, 16'h0200, 16'h0300, o, fl, lat);
        chk("bpc4_round", 32'(o), 32'h00AB);
        do_div(2, 16'h9C00, 16'h0040, o, fl, lat);
        chk("bpc4_sat_out", 32'(o), 32'h8000);
        chk("bpc4_sat_flags", 32'(fl), 32'b010);

        ordy[0] = 1'b0;
        do_div(0, 16'h0300, 16'h0200, o, fl, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out", 32'(q0), 32'h0180);
            chk("bp_valid", 32'(ov[0]), 32'd1);
            chk("bp_in_ready", 32'(irdy[0]), 32'd0);
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(ov[0]), 32'd0);
        chk("bp_release_ready", 32'(irdy[0]), 32'd1);

        dividend = 16'h0300;
        divisor  = 16'h0200;
        iv[0]    = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready_low", 32'(irdy[0]), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_ready_high", 32'(irdy[0]), 32'd1);
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (ov[0]) seen = 1'b1;
        end
        chk("midrst_no_valid", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_fixed_point_div.md
Name: seq_fixed_point_div

Overview:
- Multi-cycle signed fixed-point divider with valid/ready handshakes on input and output.
- Successor to the combinational divider. Uses the same Q-format parameters, round-to-nearest and saturation semantics.
- Adds configurable radix (quotient bits per cycle), fixed latency, output backpressure and divide-by-zero detection.
- Sits in datapaths where a full-width combinational divide misses timing.

Parameters:
- WIIA, 8, dividend integer bits (incl. sign)
- WIFA, 8, dividend fraction bits
- WIIB, 8, divisor integer bits (incl. sign)
- WIFB, 8, divisor fraction bits
- WOI, 8, output integer bits (incl. sign)
- WOF, 8, output fraction bits
- ROUND, 1, 1 = round to nearest, 0 = truncate toward zero
- BPC, 1, quotient bits resolved per CALC cycle; legal range 1..WOI+WOF

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  divider idle, can accept an operand pair
- dividend  input  WIIA+WIFA  signed two's complement
- divisor  input  WIIB+WIFB  signed two's complement
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out  output  WOI+WOF  signed quotient
- upflow  output  1  positive saturation occurred
- downflow  output  1  negative saturation occurred
- div_zero  output  1  divisor was zero

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, out=0, upflow=downflow=div_zero=0, out_valid=0. in_ready=0 while rst is high, and 1 from the first cycle after rst deasserts.
- Reset mid-operation: the operation is aborted and no result is emitted.
- Definitions: N=WOI+WOF; K=ceil(N/BPC).
- Alignment widths: WRI=max(WOI+WIIB, WIIA); WRF=max(WOF+WIFB, WIFA).
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register sign = MSB(dividend) XOR MSB(divisor).
  - Register the magnitudes as two's-complement negation when negative. The most negative input maps to unsigned 2^(W-1).
  - Register both magnitudes zero-extended and aligned to WRI.WRF.
  - Register the zero-divisor flag. Go to CALC.
- CALC, for exactly K cycles:
  - Restoring division, MSB first.
  - Quotient bit of weight 2^j (j from WOI-1 down to -WOF) is 1 iff acc + divr*2^j <= divd, in which case acc is updated.
  - Each cycle resolves BPC bits. The last cycle may resolve fewer.
  - After K cycles go to FIX.
  - If the true quotient is >= 2^WOI, all N bits come out as 1.
- FIX, 1 cycle:
  - Rounding: if ROUND=1 and q is not all-ones, let r = divd - acc and s = divr*2^-WOF. If 2r > s, q = q+1. Ties round down.
  - Sign positive and q[N-1]=1: upflow=1, out = {0, all-ones}.
  - Sign negative and q[N-1]=1: out = {1, zeros}; downflow=1 iff q[N-2:0]≠0.
  - Sign negative otherwise: out = -q.
  - Sign positive otherwise: out = q.
- Divisor = 0: the magnitude path is bypassed in FIX and div_zero=1.
  - Dividend > 0: out = max positive, upflow=1.
  - Dividend < 0: out = min negative, downflow=1.
  - Dividend = 0: out = 0, no flags.
  - Latency is unchanged.
- DONE:
  - out_valid=1.
  - out and the flags stay stable while out_ready=0.
  - On out_ready, go to IDLE with out_valid=0 on the next cycle.
  - in_ready=0 in DONE; there is no same-cycle result/accept overlap.
- Latency: out_valid rises K+2 cycles after the input handshake edge. Throughput is one result per K+3 cycles minimum.
- in_valid while not in IDLE is ignored. Operands are sampled only on the handshake.

Test Plan:
- Defaults (BPC=1, K=16). 0x0300 / 0x0200 (3.0/2.0) → out=0x0180. Flags 0. out_valid exactly 18 cycles after the accept edge.
- Signs: 0xF900 / 0x0200 → 0xFC80 (−3.5). 0x0700 / 0xFE00 → 0xFC80. 0xF900 / 0xFE00 → 0x0380.
- Rounding: 0x0200 / 0x0300 → 0x00AB with ROUND=1, 0x00AA with ROUND=0. 0x0100 / 0x0300 → 0x0055 in both modes.
- Saturation:
  - 0x6400 / 0x0040 → 0x7FFF, upflow=1.
  - 0x9C00 / 0x0040 → 0x8000, downflow=1.
  - 0x8000 / 0x0100 → 0x8000, downflow=0.
- Divide-by-zero: 0x0500 / 0x0000 → 0x7FFF, upflow=1, div_zero=1. 0x0000 / 0x0000 → 0x0000, div_zero=1, no other flags. Latency 18 cycles in both cases.
- Handshake, reset, radix:
  - Hold out_ready=0 for 5 cycles after out_valid: out is stable and in_ready=0. Raise out_ready: next accept is possible one cycle later.
  - rst pulsed on CALC cycle 7: no out_valid appears, and in_ready=1 one cycle after rst drops.
  - Repeat the first scenario with BPC=4: latency is 6 cycles.
